sr2axil: RTL and testbench

- AXI-Lite master that turns 64-bit SoftReg requests into pairs of 32-bit AXI-Lite transactions.
- Write: two write beats. Read: two read beats, then one 64-bit SoftReg response.
- Sits between a SoftReg initiator (host-side arbiter or debug controller) and a 32-bit AXI-Lite register slave, e.g. an app CSR block behind the shell.
- Exactly one SoftReg request is in flight at a time.

---
 rtl/sr2axil_pkg.sv | 35 +++
 rtl/sr2axil_if.sv | 51 +++++
 rtl/sr2axil.sv | 117 +++++++++++
 tb/tb_sr2axil.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr2axil_pkg.sv
// Shared types and defaults for the SoftReg to AXI-Lite bridge.
// Latency: none (types and constants only).
// Backpressure: n/a.
package sr2axil_pkg;

  localparam logic [31:0] SR2AXIL_BASE_ADDR   = 32'h0000_0000;
  localparam logic [31:0] SR2AXIL_ADDR_STRIDE = 32'd4;
  localparam logic [1:0]  AXI_OKAY            = 2'b00;
  localparam logic [3:0]  SR2AXIL_WSTRB       = 4'hF;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [63:0] data;
  } softreg_req_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } softreg_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } sr2axil_state_t;

  // Pick the 32-bit half of a 64-bit word that belongs to beat 0 (low) or beat 1 (high).
  function automatic logic [31:0] half_sel(input logic [63:0] d, input logic hi);
    return hi ? d[63:32] : d[31:0];
  endfunction

endpackage

// File: rtl/sr2axil_if.sv
// SoftReg request/response plus 32-bit AXI-Lite master bus bundle.
// Latency: none (wiring only).
// Backpressure: carried by the grant/ready signals inside the bundle.
interface sr2axil_if;
  import sr2axil_pkg::*;

  softreg_req_t  softreg_req;
  logic          softreg_req_grant;
  softreg_resp_t softreg_resp;
  logic          softreg_resp_grant;

  logic          m_awvalid;
  logic [31:0]   m_awaddr;
  logic          m_awready;
  logic          m_wvalid;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_wready;
  logic          m_bvalid;
  logic [1:0]    m_bresp;
  logic          m_bready;
  logic          m_arvalid;
  logic [31:0]   m_araddr;
  logic          m_arready;
  logic          m_rvalid;
  logic [31:0]   m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rready;
  logic          axil_err;

  // Bridge side: accepts SoftReg, drives the AXI-Lite master channels.
  modport master (
    input  softreg_req, softreg_resp_grant,
    input  m_awready, m_wready, m_bvalid, m_bresp,
    input  m_arready, m_rvalid, m_rdata, m_rresp,
    output softreg_req_grant, softreg_resp,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_arvalid, m_araddr, m_rready, axil_err
  );

  // Environment side: SoftReg initiator plus AXI-Lite register slave.
  modport slave (
    output softreg_req, softreg_resp_grant,
    output m_awready, m_wready, m_bvalid, m_bresp,
    output m_arready, m_rvalid, m_rdata, m_rresp,
    input  softreg_req_grant, softreg_resp,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_arvalid, m_araddr, m_rready, axil_err
  );

endinterface

// File: rtl/sr2axil.sv
// Splits one 64-bit SoftReg request into two 32-bit AXI-Lite beats (write: AW/W/B x2, read: AR/R x2 + response).
// Latency: grant to IDLE 3 cycles (write), grant to softreg_resp.valid 3 cycles (read) with an always-ready slave.
// Backpressure: one request in flight; grant only in IDLE; AXI valids hold until ready; response held until resp_grant.
module sr2axil
  import sr2axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SR2AXIL_BASE_ADDR,
  parameter logic [31:0] ADDR_STRIDE = SR2AXIL_ADDR_STRIDE
) (
  input  logic       clk,
  input  logic       rst,
  sr2axil_if.master  bus
);

  sr2axil_state_t state, state_nx;

  logic [31:0] a0;
  logic [31:0] a1;
  logic [63:0] wr_data;
  logic [31:0] rd_lo;
  logic [31:0] rd_hi;
  logic [1:0]  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        err;

  logic grant;
  logic aw_vld, w_vld, ar_vld, b_rdy, r_rdy;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic b_bad, r_bad;

  // Beat counters only ever reach 2, so bit 1 set means both beats of a channel are done.
  assign a1     = a0 + ADDR_STRIDE;
  assign grant  = bus.softreg_req.valid && (state == ST_IDLE) && !rst;
  assign aw_vld = (state == ST_WRITE) && !aw_cnt[1];
  assign w_vld  = (state == ST_WRITE) && !w_cnt[1];
  assign b_rdy  = (state == ST_WRITE);
  assign ar_vld = (state == ST_READ) && !ar_cnt[1];
  assign r_rdy  = (state == ST_READ) && !r_cnt[1];

  assign aw_hs = aw_vld && bus.m_awready;
  assign w_hs  = w_vld  && bus.m_wready;
  assign b_hs  = b_rdy  && bus.m_bvalid;
  assign ar_hs = ar_vld && bus.m_arready;
  assign r_hs  = r_rdy  && bus.m_rvalid;
  assign b_bad = b_hs && (bus.m_bresp != AXI_OKAY);
  assign r_bad = r_hs && (bus.m_rresp != AXI_OKAY);

  // Next-state: the state itself records read vs write, so is_write needs no separate register.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (grant) state_nx = bus.softreg_req.is_write ? ST_WRITE : ST_READ;
      ST_WRITE: if (b_hs && (b_cnt == 2'd1)) state_nx = ST_IDLE;
      ST_READ:  if (r_hs && (r_cnt == 2'd1)) state_nx = ST_RESP;
      ST_RESP:  if (bus.softreg_resp_grant) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Drive the bus outputs; addresses and data follow each channel's own beat counter.
  always_comb begin
    bus.softreg_req_grant   = grant;
    bus.softreg_resp        = '0;
    bus.softreg_resp.valid  = (state == ST_RESP);
    bus.softreg_resp.data   = {rd_hi, rd_lo};
    bus.m_awvalid           = aw_vld;
    bus.m_awaddr            = (aw_cnt == 2'd0) ? a0 : a1;
    bus.m_wvalid            = w_vld;
    bus.m_wdata             = half_sel(wr_data, (w_cnt != 2'd0));
    bus.m_wstrb             = SR2AXIL_WSTRB;
    bus.m_bready            = b_rdy;
    bus.m_arvalid           = ar_vld;
    bus.m_araddr            = (ar_cnt == 2'd0) ? a0 : a1;
    bus.m_rready            = r_rdy;
    bus.axil_err            = err;
  end

  // State register, request capture, beat counting, read-data capture and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a0      <= '0;
      wr_data <= '0;
      rd_lo   <= '0;
      rd_hi   <= '0;
      aw_cnt  <= '0;
      w_cnt   <= '0;
      b_cnt   <= '0;
      ar_cnt  <= '0;
      r_cnt   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        a0      <= BASE_ADDR + bus.softreg_req.addr;
        wr_data <= bus.softreg_req.data;
        aw_cnt  <= '0;
        w_cnt   <= '0;
        b_cnt   <= '0;
        ar_cnt  <= '0;
        r_cnt   <= '0;
      end else begin
        if (aw_hs) aw_cnt <= aw_cnt + 2'd1;
        if (w_hs)  w_cnt  <= w_cnt + 2'd1;
        if (b_hs)  b_cnt  <= b_cnt + 2'd1;
        if (ar_hs) ar_cnt <= ar_cnt + 2'd1;
        if (r_hs)  r_cnt  <= r_cnt + 2'd1;
      end
      // R beats return in order, so the first beat is always the low half.
      if (r_hs) begin
        if (r_cnt == 2'd0) rd_lo <= bus.m_rdata;
        else               rd_hi <= bus.m_rdata;
      end
      if (b_bad || r_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr2axil.sv
// Self-checking bench: directed and random SoftReg traffic against a memory-model AXI-Lite slave.
// Latency: checks 3-cycle write/read latency with an always-ready slave.
// Backpressure: exercises W stalls, random ready/response delays and response-grant holdoff.
module tb_sr2axil;
  import sr2axil_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr2axil_if bus ();
  sr2axil_if busb ();

  sr2axil dut (.clk(clk), .rst(rst), .bus(bus));
  sr2axil #(.BASE_ADDR(32'h0000_1000), .ADDR_STRIDE(32'd4)) dut_b (.clk(clk), .rst(rst), .bus(busb));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave knobs and bench-side reference model.
  bit  rand_mode = 1'b0;
  int  w_hold = 0;
  bit  err_r_odd = 1'b0;
  bit  exp_err = 1'b0;
  int  exp_b_total = 0;
  int  b_total = 0;
  int  last_b_cyc = 0, aw1_cyc = 0, w0_cyc = 0;
  logic [31:0] exp_aw_q[$], exp_w_q[$], exp_ar_q[$];
  logic [63:0] exp_rd_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] b_aw_log[$], b_w_log[$], b_ar_log[$];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] slv_get(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AXI-Lite slave for the main DUT: decides readies/responses on the falling edge, logs the
  // handshakes that the next rising edge will complete, and answers in the same cycle when allowed.
  initial begin : slave
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic pv_aw, pv_w, pv_ar, b_hold, r_hold, aw_idx, w_idx;
    logic [31:0] pv_awaddr, pv_wdata, pv_araddr;
    logic [31:0] s_aw_q[$], s_w_q[$], r_q[$];
    int b_pend, r_seq;
    bus.m_awready = 0; bus.m_wready = 0; bus.m_arready = 0;
    bus.m_bvalid = 0; bus.m_bresp = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0;
    pv_aw = 0; pv_w = 0; pv_ar = 0; b_hold = 0; r_hold = 0; aw_idx = 0; w_idx = 0;
    pv_awaddr = 0; pv_wdata = 0; pv_araddr = 0; b_pend = 0; r_seq = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        s_aw_q.delete(); s_w_q.delete(); r_q.delete();
        b_pend = 0; r_seq = 0; pv_aw = 0; pv_w = 0; pv_ar = 0; b_hold = 0; r_hold = 0;
        aw_idx = 0; w_idx = 0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_arready = 0;
        bus.m_bvalid = 0; bus.m_rvalid = 0; bus.m_bresp = 0; bus.m_rresp = 0; bus.m_rdata = 0;
      end else begin
        if (pv_aw) chk("aw_stable", {31'd0, bus.m_awvalid, bus.m_awaddr}, {31'd0, 1'b1, pv_awaddr});
        if (pv_w)  chk("w_stable",  {31'd0, bus.m_wvalid,  bus.m_wdata},  {31'd0, 1'b1, pv_wdata});
        if (pv_ar) chk("ar_stable", {31'd0, bus.m_arvalid, bus.m_araddr}, {31'd0, 1'b1, pv_araddr});
        bus.m_awready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.m_arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (w_hold > 0) begin
          bus.m_wready = 1'b0;
          if (bus.m_wvalid) w_hold--;
        end else begin
          bus.m_wready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        aw_hs = bus.m_awvalid && bus.m_awready;
        w_hs  = bus.m_wvalid && bus.m_wready;
        ar_hs = bus.m_arvalid && bus.m_arready;
        if (aw_hs) begin
          chk("aw_expected", 64'(exp_aw_q.size() > 0), 64'd1);
          if (exp_aw_q.size() > 0) chk("aw_addr", 64'(bus.m_awaddr), 64'(exp_aw_q.pop_front()));
          if (aw_idx) aw1_cyc = cyc;
          aw_idx = ~aw_idx;
          s_aw_q.push_back(bus.m_awaddr);
        end
        if (w_hs) begin
          chk("w_expected", 64'(exp_w_q.size() > 0), 64'd1);
          if (exp_w_q.size() > 0)
            chk("w_data_strb", {28'd0, bus.m_wstrb, bus.m_wdata}, {28'd0, 4'hF, exp_w_q.pop_front()});
          if (!w_idx) w0_cyc = cyc;
          w_idx = ~w_idx;
          s_w_q.push_back(bus.m_wdata);
        end
        while (s_aw_q.size() > 0 && s_w_q.size() > 0) begin
          slv_mem[s_aw_q.pop_front()] = s_w_q.pop_front();
          b_pend++;
        end
        if (ar_hs) begin
          chk("ar_expected", 64'(exp_ar_q.size() > 0), 64'd1);
          if (exp_ar_q.size() > 0) chk("ar_addr", 64'(bus.m_araddr), 64'(exp_ar_q.pop_front()));
          r_q.push_back(slv_get(bus.m_araddr));
        end
        bus.m_bvalid = b_hold || (b_pend > 0 && (!rand_mode || $urandom_range(0, 1) == 1));
        bus.m_bresp  = 2'b00;
        b_hs = bus.m_bvalid && bus.m_bready;
        if (b_hs) begin b_pend--; b_total++; last_b_cyc = cyc; end
        b_hold = bus.m_bvalid && !bus.m_bready;
        bus.m_rvalid = r_hold || (r_q.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 1));
        bus.m_rdata  = bus.m_rvalid ? r_q[0] : 32'd0;
        bus.m_rresp  = (bus.m_rvalid && err_r_odd && (r_seq % 2 == 1)) ? 2'b10 : 2'b00;
        r_hs = bus.m_rvalid && bus.m_rready;
        if (r_hs) begin
          void'(r_q.pop_front());
          r_seq++;
          if (bus.m_rresp != 2'b00) exp_err = 1'b1;
        end
        r_hold = bus.m_rvalid && !bus.m_rready;
        pv_aw = bus.m_awvalid && !bus.m_awready; pv_awaddr = bus.m_awaddr;
        pv_w  = bus.m_wvalid  && !bus.m_wready;  pv_wdata  = bus.m_wdata;
        pv_ar = bus.m_arvalid && !bus.m_arready; pv_araddr = bus.m_araddr;
      end
    end
  end

  // Trivial always-ready slave for the offset-base instance; read data is a fixed function of address.
  initial begin : slave_b
    busb.m_awready = 1; busb.m_wready = 1; busb.m_arready = 1;
    busb.m_bvalid = 0; busb.m_bresp = 0; busb.m_rvalid = 0; busb.m_rdata = 0; busb.m_rresp = 0;
    forever begin
      @(negedge clk); #1;
      busb.m_bvalid = busb.m_wvalid;
      busb.m_rvalid = busb.m_arvalid;
      busb.m_rdata  = busb.m_araddr ^ 32'hA5A5_A5A5;
      if (!rst) begin
        if (busb.m_awvalid) b_aw_log.push_back(busb.m_awaddr);
        if (busb.m_wvalid)  b_w_log.push_back(busb.m_wdata);
        if (busb.m_arvalid) b_ar_log.push_back(busb.m_araddr);
      end
    end
  end

  // Present a request until granted, then load the expected beats into the model (BASE_ADDR 0, stride 4).
  task automatic send_req(input bit wr, input logic [31:0] addr, input logic [63:0] data, output int gcyc);
    logic [31:0] a0, a1;
    bit got;
    got = 0; gcyc = -1;
    bus.softreg_req = '{1'b1, wr, addr, data};
    for (int i = 0; i < 300 && !got; i++) begin
      #2;
      if (bus.softreg_req_grant === 1'b1) begin got = 1; gcyc = cyc; end
      @(negedge clk);
    end
    bus.softreg_req.valid = 1'b0;
    chk("grant_seen", 64'(got), 64'd1);
    a0 = addr;
    a1 = a0 + 32'd4;
    if (got && wr) begin
      exp_aw_q.push_back(a0); exp_aw_q.push_back(a1);
      exp_w_q.push_back(data[31:0]); exp_w_q.push_back(data[63:32]);
      ref_mem[a0] = data[31:0]; ref_mem[a1] = data[63:32];
      exp_b_total += 2;
    end else if (got) begin
      exp_ar_q.push_back(a0); exp_ar_q.push_back(a1);
      exp_rd_q.push_back({ref_get(a1), ref_get(a0)});
    end
  endtask

  task automatic wait_resp(input int hold, output int vcyc);
    logic [63:0] exp;
    bit got;
    got = 0; vcyc = -1;
    chk("rd_expected", 64'(exp_rd_q.size() > 0), 64'd1);
    exp = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 64'd0;
    for (int i = 0; i < 300 && !got; i++) begin
      #2;
      if (bus.softreg_resp.valid === 1'b1) begin got = 1; vcyc = cyc; end
      else @(negedge clk);
    end
    chk("resp_seen", 64'(got), 64'd1);
    if (got) begin
      for (int k = 0; k < hold; k++) begin
        chk("resp_held_data", bus.softreg_resp.data, exp);
        @(negedge clk); #2;
        chk("resp_held_valid", 64'(bus.softreg_resp.valid), 64'd1);
      end
      chk("resp_data", bus.softreg_resp.data, exp);
      bus.softreg_resp_grant = 1'b1;
      @(negedge clk);
      bus.softreg_resp_grant = 1'b0;
      #2;
      chk("resp_drop", 64'(bus.softreg_resp.valid), 64'd0);
    end
    @(negedge clk);
  endtask

  task automatic wait_writes_done();
    for (int i = 0; i < 300 && b_total != exp_b_total; i++) @(negedge clk);
    @(negedge clk); #2;
    chk("b_count", 64'(b_total), 64'(exp_b_total));
    chk("no_wr_resp", 64'(bus.softreg_resp.valid), 64'd0);
    @(negedge clk);
  endtask

  initial begin : main
    int g1, g2, v, c0;
    bit gotb;
    logic [63:0] bresp_dat;
    bus.softreg_req = '0; bus.softreg_resp_grant = 1'b0;
    busb.softreg_req = '0; busb.softreg_resp_grant = 1'b1;

    // Reset: a pending request must not be granted and every output is quiet.
    bus.softreg_req = '{1'b1, 1'b1, 32'h10, 64'h1};
    repeat (3) @(negedge clk);
    #2;
    chk("rst_grant", 64'(bus.softreg_req_grant), 64'd0);
    chk("rst_valids", {58'd0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready,
                       bus.softreg_resp.valid}, 64'd0);
    chk("rst_err", 64'(bus.axil_err), 64'd0);
    @(negedge clk);
    bus.softreg_req = '0;
    rst = 1'b0;
    @(negedge clk);

    // Write with always-ready slave; the back-to-back request shows the 3-cycle turnaround.
    send_req(1'b1, 32'h10, 64'hAAAA_BBBB_CCCC_DDDD, g1);
    send_req(1'b1, 32'h40, 64'h0102_0304_0506_0708, g2);
    chk("wr_latency", 64'(g2 - g1), 64'd3);
    wait_writes_done();

    // W stalled 5 cycles: both AW beats lead, next grant only after the second B.
    w_hold = 5;
    send_req(1'b1, 32'h30, 64'h5555_6666_7777_8888, g1);
    send_req(1'b0, 32'h30, 64'h0, g2);
    chk("aw_before_w", 64'(aw1_cyc < w0_cyc), 64'd1);
    chk("grant_after_b", 64'(g2), 64'(last_b_cyc + 1));
    wait_resp(0, v);

    // Read from preloaded slave data, held 4 cycles under response backpressure.
    slv_mem[32'h20] = 32'h1111_2222; slv_mem[32'h24] = 32'h3333_4444;
    ref_mem[32'h20] = 32'h1111_2222; ref_mem[32'h24] = 32'h3333_4444;
    send_req(1'b0, 32'h20, 64'h0, g1);
    wait_resp(4, v);
    chk("rd_latency", 64'(v - g1), 64'd3);

    // Offset base and 32-bit wrap on the second instance.
    busb.softreg_req = '{1'b1, 1'b1, 32'hFFFF_FFFC, 64'h0123_4567_89AB_CDEF};
    gotb = 0;
    for (int i = 0; i < 20 && !gotb; i++) begin #2; if (busb.softreg_req_grant === 1'b1) gotb = 1; @(negedge clk); end
    busb.softreg_req = '{1'b1, 1'b0, 32'hFFFF_FFFC, 64'h0};
    gotb = 0;
    for (int i = 0; i < 20 && !gotb; i++) begin #2; if (busb.softreg_req_grant === 1'b1) gotb = 1; @(negedge clk); end
    busb.softreg_req = '0;
    chk("b_rd_grant", 64'(gotb), 64'd1);
    bresp_dat = 64'd0;
    gotb = 0;
    for (int i = 0; i < 20 && !gotb; i++) begin
      #2;
      if (busb.softreg_resp.valid === 1'b1) begin gotb = 1; bresp_dat = busb.softreg_resp.data; end
      @(negedge clk);
    end
    chk("b_aw_count", 64'(b_aw_log.size()), 64'd2);
    chk("b_ar_count", 64'(b_ar_log.size()), 64'd2);
    if (b_aw_log.size() == 2) chk("b_aw_addrs", {b_aw_log[0], b_aw_log[1]}, {32'h0000_0FFC, 32'h0000_1000});
    if (b_w_log.size() == 2)  chk("b_w_data", {b_w_log[1], b_w_log[0]}, 64'h0123_4567_89AB_CDEF);
    if (b_ar_log.size() == 2) chk("b_ar_addrs", {b_ar_log[0], b_ar_log[1]}, {32'h0000_0FFC, 32'h0000_1000});
    chk("b_resp", bresp_dat, {32'h0000_1000 ^ 32'hA5A5_A5A5, 32'h0000_0FFC ^ 32'hA5A5_A5A5});

    // Random mix with random readies and response delays; reads see earlier writes.
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        send_req(1'b1, ra, {$urandom, $urandom}, g1);
        wait_writes_done();
      end else begin
        send_req(1'b0, ra, 64'h0, g1);
        wait_resp(int'($urandom_range(0, 3)), v);
      end
    end
    rand_mode = 1'b0;
    chk("err_clean", 64'(bus.axil_err), 64'd0);

    // SLVERR on the second R beat: data still returned, flag sticky across OKAY traffic.
    err_r_odd = 1'b1;
    send_req(1'b0, 32'h08, 64'h0, g1);
    wait_resp(0, v);
    err_r_odd = 1'b0;
    chk("err_model_set", 64'(exp_err), 64'd1);
    chk("err_set", 64'(bus.axil_err), 64'(exp_err));
    send_req(1'b1, 32'h18, 64'hDEAD_0000_BEEF_0000, g1);
    wait_writes_done();
    send_req(1'b0, 32'h18, 64'h0, g1);
    wait_resp(1, v);
    chk("err_sticky", 64'(bus.axil_err), 64'd1);

    // Reset in WRITE after one AW beat: everything drops, error clears, next read is normal.
    w_hold = 10;
    send_req(1'b1, 32'h50, 64'hFEED_FACE_CAFE_F00D, g1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    chk("midrst_valids", {58'd0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready,
                          bus.softreg_resp.valid}, 64'd0);
    chk("midrst_err", 64'(bus.axil_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    w_hold = 0;
    exp_err = 1'b0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_rd_q.delete();
    exp_b_total = b_total;
    c0 = cyc;
    send_req(1'b0, 32'h60, 64'h0, g1);
    chk("idle_after_rst", 64'(g1 - c0), 64'd0);
    wait_resp(1, v);
    chk("rd_latency_after_rst", 64'(v - g1), 64'd3);
    chk("err_after_rst", 64'(bus.axil_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
